// File: rtl/crc_par_pkg.sv
// Shared types, constants and helpers for the parallel CRC engine.
// Optional feature macro used by the engine: CRC_PAR_RESIDUE_CHECK_EN.
package crc_par_pkg;

    // Frame-level engine state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } crc_state_t;

    // Common generator polynomials (implicit top bit omitted)
    localparam logic [15:0] CRC16_CCITT = 16'h1021;
    localparam logic [31:0] CRC32       = 32'h04C11DB7;

    // Reverse the low w bits of v; bits above w come back as zero
    function automatic logic [63:0] reverse_bits(input logic [63:0] v, input int unsigned w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < int'(w)) begin
                r[i] = v[int'(w) - 1 - i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_par_step.sv
// Combinational CRC fold of one DATA_W-bit beat into a CRC_W-bit register.
// Bytes are taken first-in-stream from the top of i_data, each folded MSB first
// (or LSB first when REFLECT=1, which is the same as folding the reversed byte).
module crc_par_step
    import crc_par_pkg::*;
#(
    parameter int                CRC_W   = 16,
    parameter int                DATA_W  = 8,
    parameter logic [CRC_W-1:0]  POLY    = CRC_W'(CRC16_CCITT),
    parameter bit                REFLECT = 1'b0
) (
    input  logic [CRC_W-1:0]  i_crc,
    input  logic [DATA_W-1:0] i_data,
    output logic [CRC_W-1:0]  o_crc
);

    localparam int NBYTES = DATA_W / 8;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_byte
            logic [7:0]       w_raw;
            logic [CRC_W-1:0] w_byte_in;
            logic [CRC_W-1:0] w_byte_out;

            assign w_raw = i_data[DATA_W-1-8*gi -: 8];

            // Each byte stage starts from the previous byte's result
            if (gi == 0) begin : g_first
                assign w_byte_in = i_crc;
            end else begin : g_chain
                assign w_byte_in = g_byte[gi-1].w_byte_out;
            end

            for (gj = 0; gj < 8; gj++) begin : g_bit
                logic [CRC_W-1:0] w_prev;
                logic [CRC_W-1:0] w_next;
                logic             w_d;
                logic             w_fb;

                if (gj == 0) begin : g_b0
                    assign w_prev = w_byte_in;
                end else begin : g_bn
                    assign w_prev = g_bit[gj-1].w_next;
                end

                // gj counts bits in fold order; reflection flips which end goes first
                assign w_d    = REFLECT ? w_raw[gj] : w_raw[7-gj];
                assign w_fb   = w_prev[CRC_W-1] ^ w_d;
                assign w_next = {w_prev[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
            end

            assign w_byte_out = g_bit[7].w_next;
        end
    endgenerate

    assign o_crc = g_byte[NBYTES-1].w_byte_out;

endmodule

// File: rtl/crc_parallel_engine.sv
// Framed, handshaked parallel CRC engine: one beat per cycle, result held
// until consumed. Define CRC_PAR_RESIDUE_CHECK_EN to add the crc_ok output
// (result compared against RESIDUE).
module crc_parallel_engine
    import crc_par_pkg::*;
#(
    parameter int                CRC_W   = 16,
    parameter int                DATA_W  = 8,
    parameter logic [CRC_W-1:0]  POLY    = CRC_W'(CRC16_CCITT),
    parameter logic [CRC_W-1:0]  INIT    = '1,
    parameter logic [CRC_W-1:0]  XOROUT  = '0,
    parameter bit                REFLECT = 1'b0,
    parameter logic [CRC_W-1:0]  RESIDUE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sop,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CRC_W-1:0]  crc_out,
    output logic              busy
`ifdef CRC_PAR_RESIDUE_CHECK_EN
    ,
    output logic              crc_ok
`endif
);

    generate
        if (CRC_W < 8 || CRC_W > 32 || DATA_W < 8 || DATA_W > 64 || (DATA_W % 8) != 0) begin : g_bad_width
            $fatal(1, "crc_parallel_engine: illegal CRC_W/DATA_W");
        end
    endgenerate

    crc_state_t       r_state;
    logic [CRC_W-1:0] r_crc;
    logic [CRC_W-1:0] r_crc_out;
    logic             r_out_valid;
    logic             r_busy;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_seed;
    logic [CRC_W-1:0] w_step_in;
    logic [CRC_W-1:0] w_step_out;
    logic [CRC_W-1:0] w_result;

    // A held result blocks new beats unless it is being consumed this cycle
    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;

    // Any beat outside RUN opens a frame; in_sop inside RUN restarts one
    assign w_seed    = (r_state != ST_RUN) || in_sop;
    assign w_step_in = w_seed ? INIT : r_crc;

    crc_par_step #(
        .CRC_W   (CRC_W),
        .DATA_W  (DATA_W),
        .POLY    (POLY),
        .REFLECT (REFLECT)
    ) u_step (
        .i_crc  (w_step_in),
        .i_data (in_data),
        .o_crc  (w_step_out)
    );

    assign w_result = (REFLECT ? CRC_W'(reverse_bits(64'(w_step_out), CRC_W)) : w_step_out) ^ XOROUT;

    // Frame FSM, running register and held result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_crc       <= INIT;
            r_crc_out   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_crc <= w_step_out;
                if (in_last) begin
                    r_state     <= ST_DONE;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_crc_out   <= w_result;
                end else begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b1;
                end
            end else if (r_state == ST_DONE && out_ready) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign crc_out   = r_crc_out;
    assign busy      = r_busy;

`ifdef CRC_PAR_RESIDUE_CHECK_EN
    logic r_crc_ok;

    // Residue flag tracks the held result and drops when it is consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc_ok <= 1'b0;
        end else if (w_accept && in_last) begin
            r_crc_ok <= (w_result == RESIDUE);
        end else if (r_out_valid && out_ready) begin
            r_crc_ok <= 1'b0;
        end
    end

    assign crc_ok = r_crc_ok;
`endif

endmodule

// File: tb/tb_crc_parallel_engine.sv
// Testbench for crc_parallel_engine: three 8-bit engines (CCITT-FALSE,
// XMODEM-style INIT=0, reflected CRC-32) share one stimulus bus, and a 16-bit
// beat engine has its own bus for back-pressure tests.
// Residue checks run when CRC_PAR_RESIDUE_CHECK_EN is defined.
module tb_crc_parallel_engine;

    typedef logic [7:0] bq_t [$];

    typedef struct {
        logic [7:0]  msg [16];
        int          len;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic [31:0] exp_c;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_sop, in_last, out_ready;
    logic [7:0]  in_data;
    logic        a_in_ready, a_out_valid, a_busy;
    logic [15:0] a_crc_out;
    logic        b_in_ready, b_out_valid, b_busy;
    logic [15:0] b_crc_out;
    logic        c_in_ready, c_out_valid, c_busy;
    logic [31:0] c_crc_out;

    logic        d_in_valid, d_in_sop, d_in_last, d_out_ready;
    logic [15:0] d_in_data;
    logic        d_in_ready, d_out_valid, d_busy;
    logic [15:0] d_crc_out;
`ifdef CRC_PAR_RESIDUE_CHECK_EN
    logic a_crc_ok, b_crc_ok, c_crc_ok, d_crc_ok;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] got_a[$], got_b[$], got_c[$], got_d[$];

    crc_parallel_engine #(.CRC_W(16), .DATA_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_sop(in_sop), .in_last(in_last),
        .out_valid(a_out_valid), .out_ready(out_ready), .crc_out(a_crc_out), .busy(a_busy)
`ifdef CRC_PAR_RESIDUE_CHECK_EN
        , .crc_ok(a_crc_ok)
`endif
    );

    crc_parallel_engine #(.CRC_W(16), .DATA_W(8), .INIT(16'h0000)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_sop(in_sop), .in_last(in_last),
        .out_valid(b_out_valid), .out_ready(out_ready), .crc_out(b_crc_out), .busy(b_busy)
`ifdef CRC_PAR_RESIDUE_CHECK_EN
        , .crc_ok(b_crc_ok)
`endif
    );

    crc_parallel_engine #(.CRC_W(32), .DATA_W(8), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
                          .XOROUT(32'hFFFFFFFF), .REFLECT(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .in_sop(in_sop), .in_last(in_last),
        .out_valid(c_out_valid), .out_ready(out_ready), .crc_out(c_crc_out), .busy(c_busy)
`ifdef CRC_PAR_RESIDUE_CHECK_EN
        , .crc_ok(c_crc_ok)
`endif
    );

    crc_parallel_engine #(.CRC_W(16), .DATA_W(16)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_data(d_in_data), .in_sop(d_in_sop), .in_last(d_in_last),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .crc_out(d_crc_out), .busy(d_busy)
`ifdef CRC_PAR_RESIDUE_CHECK_EN
        , .crc_ok(d_crc_ok)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Collect every consumed result, sampled mid-cycle
    always @(negedge clk) begin
        if (a_out_valid && out_ready)   got_a.push_back(32'(a_crc_out));
        if (b_out_valid && out_ready)   got_b.push_back(32'(b_crc_out));
        if (c_out_valid && out_ready)   got_c.push_back(c_crc_out);
        if (d_out_valid && d_out_ready) got_d.push_back(32'(d_crc_out));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = v[w-1-i];
        return r;
    endfunction

    // Reference CRC: plain bitwise long division over the byte list.
    // The reflected case uses the right-shifting form with a reversed polynomial.
    function automatic logic [31:0] model_crc(input bq_t msg, input int w, input logic [31:0] poly,
                                              input logic [31:0] init, input logic [31:0] xo,
                                              input bit refl);
        logic [31:0] mask, r, p;
        logic        fb;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        if (!refl) begin
            r = init & mask;
            foreach (msg[k]) begin
                for (int b = 7; b >= 0; b--) begin
                    fb = r[w-1] ^ msg[k][b];
                    r  = (r << 1) & mask;
                    if (fb) r = r ^ poly;
                end
            end
        end else begin
            p = rev(poly, w);
            r = rev(init, w);
            foreach (msg[k]) begin
                for (int b = 0; b < 8; b++) begin
                    fb = r[0] ^ msg[k][b];
                    r  = r >> 1;
                    if (fb) r = r ^ p;
                end
            end
        end
        return (r ^ xo) & mask;
    endfunction

    function automatic logic [31:0] mdl_a(input bq_t m); return model_crc(m, 16, 32'h1021, 32'hFFFF, 32'h0, 1'b0); endfunction
    function automatic logic [31:0] mdl_b(input bq_t m); return model_crc(m, 16, 32'h1021, 32'h0000, 32'h0, 1'b0); endfunction
    function automatic logic [31:0] mdl_c(input bq_t m); return model_crc(m, 32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1); endfunction

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    // Drive a byte stream on the shared bus, one beat per accepted cycle
    task automatic send_abc(input bq_t msg, input bit do_sop, input bit do_last);
        for (int i = 0; i < msg.size(); i++) begin
            int guard;
            bit acc;
            guard    = 0;
            acc      = 1'b0;
            in_valid = 1'b1;
            in_data  = msg[i];
            in_sop   = do_sop && (i == 0);
            in_last  = do_last && (i == msg.size() - 1);
            while (!acc && guard < 50) begin
                @(negedge clk);
                acc = a_in_ready;
                @(posedge clk); #1;
                guard++;
            end
            if (!acc) check("abc_accept_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_last  = 1'b0;
    endtask

    // Present one 16-bit beat to the wide engine until it is accepted
    task automatic send_d_beat(input logic [15:0] data, input bit sop, input bit last);
        int guard;
        bit acc;
        guard      = 0;
        acc        = 1'b0;
        d_in_valid = 1'b1;
        d_in_data  = data;
        d_in_sop   = sop;
        d_in_last  = last;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = d_in_ready;
            @(posedge clk); #1;
            guard++;
        end
        if (!acc) check("d_accept_timeout", 32'd0, 32'd1);
        d_in_valid = 1'b0;
        d_in_sop   = 1'b0;
        d_in_last  = 1'b0;
    endtask

    initial begin
        vec_t        vecs [5];
        bq_t         m;
        logic [31:0] exp_d;
        logic [31:0] eqa[$], eqb[$], eqc[$], eqd[$];
        int          nb, t0, t1, guard;
        string       s;

        rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
        d_in_valid = 1'b0; d_in_sop = 1'b0; d_in_last = 1'b0; d_in_data = '0; d_out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk); #1;
        check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_a_crc_out",   32'(a_crc_out),   32'd0);
        check("rst_a_busy",      32'(a_busy),      32'd0);
        check("rst_a_in_ready",  32'(a_in_ready),  32'd1);
        check("rst_c_crc_out",   c_crc_out,        32'd0);
        check("rst_d_in_ready",  32'(d_in_ready),  32'd1);
`ifdef CRC_PAR_RESIDUE_CHECK_EN
        check("rst_a_crc_ok",    32'(a_crc_ok),    32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Vector table: standard check value, single byte, random frames
        s = "123456789";
        vecs[0].len = 9;
        for (int j = 0; j < 9; j++) vecs[0].msg[j] = s[j];
        vecs[0].exp_a = 16'h29B1; vecs[0].exp_b = 16'h31C3; vecs[0].exp_c = 32'hCBF43926;
        vecs[1].len = 1;
        vecs[1].msg[0] = 8'h31;
        for (int v = 2; v < 5; v++) begin
            vecs[v].len = $urandom_range(1, 16);
            for (int j = 0; j < 16; j++) vecs[v].msg[j] = 8'($urandom);
        end
        for (int v = 1; v < 5; v++) begin
            m.delete();
            for (int j = 0; j < vecs[v].len; j++) m.push_back(vecs[v].msg[j]);
            vecs[v].exp_a = 16'(mdl_a(m));
            vecs[v].exp_b = 16'(mdl_b(m));
            vecs[v].exp_c = mdl_c(m);
        end

        for (int v = 0; v < 5; v++) begin
            m.delete();
            for (int j = 0; j < vecs[v].len; j++) m.push_back(vecs[v].msg[j]);
            send_abc(m, 1'b1, 1'b1);
            $display("frame %0d len=%0d a=%h b=%h c=%h", v, vecs[v].len, a_crc_out, b_crc_out, c_crc_out);
            check("tbl_out_valid", 32'(a_out_valid), 32'd1);
            check("tbl_crc_a", 32'(a_crc_out), 32'(vecs[v].exp_a));
            check("tbl_crc_b", 32'(b_crc_out), 32'(vecs[v].exp_b));
            check("tbl_crc_c", c_crc_out, vecs[v].exp_c);
            check("tbl_busy_done", 32'(a_busy), 32'd0);
            @(posedge clk); #1;
            check("tbl_valid_one_cycle", 32'(a_out_valid), 32'd0);
        end

        // Back-to-back random frames at full throughput
        got_a.delete(); got_b.delete(); got_c.delete();
        nb = 0;
        t0 = cyc;
        for (int f = 0; f < 4; f++) begin
            int len;
            len = $urandom_range(1, 6);
            m.delete();
            for (int j = 0; j < len; j++) m.push_back(8'($urandom));
            eqa.push_back(mdl_a(m)); eqb.push_back(mdl_b(m)); eqc.push_back(mdl_c(m));
            nb += len;
            send_abc(m, 1'b1, 1'b1);
        end
        t1 = cyc;
        check("b2b_cycles", 32'(t1 - t0), 32'(nb));
        repeat (2) @(posedge clk); #1;
        check("b2b_count", 32'(got_a.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_a.size() && i < got_b.size() && i < got_c.size()) begin
                $display("b2b frame %0d a=%h b=%h c=%h", i, got_a[i], got_b[i], got_c[i]);
                check("b2b_crc_a", got_a[i], eqa[i]);
                check("b2b_crc_b", got_b[i], eqb[i]);
                check("b2b_crc_c", got_c[i], eqc[i]);
            end
        end

        // Reset mid-frame aborts it; the resent frame yields one result
        got_b.delete();
        send_abc(str2q("1234"), 1'b1, 1'b0);
        check("midrst_busy_before", 32'(b_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy_async", 32'(b_busy), 32'd0);
        check("midrst_no_valid", 32'(b_out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_abc(str2q("123456789"), 1'b1, 1'b1);
        repeat (3) @(posedge clk); #1;
        check("midrst_count", 32'(got_b.size()), 32'd1);
        if (got_b.size() > 0) check("midrst_crc", got_b[0], 32'h31C3);

        // Mid-frame in_sop discards the partial frame
        got_a.delete();
        send_abc(str2q("abc"), 1'b1, 1'b0);
        send_abc(str2q("123456789"), 1'b1, 1'b1);
        repeat (2) @(posedge clk); #1;
        check("resop_count", 32'(got_a.size()), 32'd1);
        if (got_a.size() > 0) check("resop_crc", got_a[0], 32'h29B1);

`ifdef CRC_PAR_RESIDUE_CHECK_EN
        // Frame carrying its own CRC leaves the residue
        m = str2q("123456789"); m.push_back(8'h29); m.push_back(8'hB1);
        send_abc(m, 1'b1, 1'b1);
        check("residue_ok", 32'(a_crc_ok), 32'd1);
        check("residue_crc", 32'(a_crc_out), 32'd0);
        @(posedge clk); #1;
        check("residue_ok_drop", 32'(a_crc_ok), 32'd0);
        m = str2q("123456789"); m.push_back(8'h29); m.push_back(8'hB0);
        send_abc(m, 1'b1, 1'b1);
        check("residue_bad", 32'(a_crc_ok), 32'd0);
        check("residue_bad_crc", 32'(a_crc_out), mdl_a(m));
        @(posedge clk); #1;
`endif

        // 16-bit beats with the consumer stalled for 5 cycles
        exp_d = mdl_a(str2q("12345678"));
        d_out_ready = 1'b0;
        send_d_beat(16'h3132, 1'b1, 1'b0);
        send_d_beat(16'h3334, 1'b0, 1'b0);
        send_d_beat(16'h3536, 1'b0, 1'b0);
        send_d_beat(16'h3738, 1'b0, 1'b1);
        $display("wide frame crc=%h", d_crc_out);
        check("wide_valid", 32'(d_out_valid), 32'd1);
        check("wide_crc", 32'(d_crc_out), exp_d);
        d_in_valid = 1'b1; d_in_data = 16'h3132; d_in_sop = 1'b1; d_in_last = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(d_in_ready), 32'd0);
            @(posedge clk); #1;
            check("bp_crc_stable", 32'(d_crc_out), exp_d);
            check("bp_valid_held", 32'(d_out_valid), 32'd1);
        end
        d_out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(d_in_ready), 32'd1);
        @(posedge clk); #1;
        d_in_valid = 1'b0; d_in_sop = 1'b0; d_in_last = 1'b0;
        check("release_valid", 32'(d_out_valid), 32'd1);
        check("release_crc", 32'(d_crc_out), mdl_a(str2q("12")));
        @(posedge clk); #1;
        check("release_drain", 32'(d_out_valid), 32'd0);

        // Random frames with random source gaps and consumer stalls
        got_d.delete();
        for (int f = 0; f < 6; f++) begin
            int len;
            len = $urandom_range(1, 4);
            m.delete();
            for (int j = 0; j < 2 * len; j++) m.push_back(8'($urandom));
            eqd.push_back(mdl_a(m));
            for (int bt = 0; bt < len; bt++) begin
                bit acc;
                acc       = 1'b0;
                guard     = 0;
                d_in_data = {m[2*bt], m[2*bt+1]};
                d_in_sop  = (bt == 0);
                d_in_last = (bt == len - 1);
                while (!acc && guard < 200) begin
                    d_in_valid  = ($urandom_range(0, 2) != 0);
                    d_out_ready = ($urandom_range(0, 2) != 0);
                    @(negedge clk);
                    acc = d_in_valid && d_in_ready;
                    @(posedge clk); #1;
                    guard++;
                end
                if (!acc) check("rand_accept_timeout", 32'd0, 32'd1);
            end
        end
        d_in_valid = 1'b0; d_in_sop = 1'b0; d_in_last = 1'b0; d_out_ready = 1'b1;
        guard = 0;
        while (got_d.size() < eqd.size() && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("rand_count", 32'(got_d.size()), 32'(eqd.size()));
        for (int i = 0; i < eqd.size(); i++) begin
            if (i < got_d.size()) begin
                $display("rand wide frame %0d crc=%h", i, got_d[i]);
                check("rand_crc", got_d[i], eqd[i]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crc_parallel_engine.md
# crc_parallel_engine

Parametrised parallel CRC engine: folds one DATA_W-bit beat per cycle into a CRC_W-bit register under any polynomial. It is the framed, handshaked successor to the fixed 8-bit CRC-16 parallel block. It sits between a byte/word stream source and a frame checker or appender. It adds start/end-of-frame framing, back-pressure, final XOR, bit reflection, and a held result with its own valid/ready handshake.

## Interface
- CRC_W, 16, CRC width in bits, 8..32
- DATA_W, 8, beat width in bits; must be a multiple of 8, 8..64
- POLY, 16'h1021, generator polynomial without the implicit top bit
- INIT, all ones, register value loaded at frame start
- XOROUT, 0, value XORed into the result
- REFLECT, 0, 1 = reflect each input byte and reflect the final register across CRC_W
- RESIDUE, 0, expected crc_out for a frame that includes its own CRC (only used with the macro)

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  beat present
- in_ready  out  1  engine accepts the beat this cycle
- in_data  in  DATA_W  beat; in_data[DATA_W-1 -: 8] is the first byte in stream order
- in_sop  in  1  beat is the first of a frame
- in_last  in  1  beat is the last of a frame
- out_valid  out  1  result held
- out_ready  in  1  consumer takes the result
- crc_out  out  CRC_W  final CRC, after reflection and XOROUT
- busy  out  1  frame in progress (state RUN)
- crc_ok  out  1  present only with the macro

## Operation
- Beat transfer occurs when in_valid && in_ready.
- States:
  - IDLE: no frame in progress.
  - RUN: frame in progress.
  - DONE: result held on crc_out / out_valid.
- In IDLE, any accepted beat starts a frame; in_sop is implied. The register is seeded from INIT before the fold. Next state is RUN, or DONE if in_last.
- In RUN, an accepted beat folds into the register. If in_sop=1 on that beat, the register re-seeds from INIT and the old frame is silently discarded. An accepted in_last beat moves to DONE.
- DONE holds crc_out until out_ready.
  - out_valid && out_ready without a new beat returns to IDLE.
  - With a new beat accepted in the same cycle, the FSM goes straight to RUN or DONE as for IDLE.
- in_ready = !out_valid || out_ready.
- Fold per byte, MSB first, in the non-reflected domain: for each bit, fb = reg[CRC_W-1] ^ d; reg = (reg << 1) ^ (fb ? POLY : 0). DATA_W/8 bytes are chained combinationally in one cycle.
- With REFLECT=1, each byte is bit-reversed before the fold.
- Result = (REFLECT ? reverse(reg) : reg) ^ XOROUT, registered into crc_out on the transfer of the last beat.
- The internal register is CRC_W bits; all arithmetic is modulo 2 and no carries are used. Widths are checked at elaboration; an illegal DATA_W or CRC_W is a fatal elaboration error.

## Timing
- Reset values:
  - state = IDLE
  - register = INIT
  - crc_out = 0
  - out_valid = 0
  - busy = 0
  - in_ready = 1
  - crc_ok = 0
- Throughput is one beat per cycle, including back-to-back frames when out_ready=1.
- Latency: crc_out/out_valid are valid the cycle after the in_last beat transfers.
- A single-beat frame (in_sop && in_last) produces a result 1 cycle later.
- Back-pressure: while out_valid && !out_ready, in_ready=0 and the register and crc_out are frozen.
- Reset asserted mid-frame aborts the frame immediately; no result is emitted.

## Configuration
- CRC_PAR_RESIDUE_CHECK_EN
  - Defined: adds output crc_ok, registered alongside crc_out, equal to (crc_out == RESIDUE). Valid while out_valid=1 and 0 otherwise.
  - Undefined: the crc_ok port and its comparator do not exist.

## Structure
- Package crc_par_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - common polynomial constants (CRC16_CCITT 16'h1021, CRC32 32'h04C11DB7)
  - reverse-bits function
- Sub-module crc_par_step: purely combinational, parameters CRC_W/DATA_W/POLY/REFLECT. Maps (reg, data) to next reg, with a generate loop over bytes and bits.
- crc_parallel_engine owns the FSM, register, output holding and handshakes.

## Test plan
- Defaults, DATA_W=8, "123456789" as 9 beats with sop on the first and last on the 9th, out_ready=1 -> crc_out=16'h29B1, out_valid for 1 cycle.
- INIT=0, same stream -> 16'h31C3; the same stream at DATA_W=8 after reset mid-frame at byte 4, then resent -> 16'h31C3 only once.
- CRC_W=32, POLY=32'h04C11DB7, INIT=FFFFFFFF, REFLECT=1, XOROUT=FFFFFFFF, "123456789" -> 32'hCBF43926.
- Defaults, DATA_W=16, "12345678" as 4 beats, out_ready held 0 for 5 cycles -> in_ready=0 and crc_out stable. After out_ready=1, a new sop beat is accepted in the release cycle.
- Mid-frame in_sop after 3 bytes, then "123456789" -> 16'h29B1; single-beat frame 0x31 ("1") with sop&last -> 1-cycle latency.
- Macro defined, RESIDUE=0: "123456789",0x29,0xB1 -> crc_ok=1. With last byte 0xB0 -> crc_ok=0.
